// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS checker/generator family: FSM states, LFSR geometry and seed.
package prbs_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'h0011;
  localparam int PREAMBLE_BYTES = 4;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    PREAMBLE = 2'd1,
    CHECK    = 2'd2
  } state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// 16-bit Fibonacci LFSR (x^16 + x^15 + 1 style feedback from bits 15 and 14), shared by checker and generator.
module prbs_lfsr
  import prbs_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              load,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_reg;

  // load wins over advance so a reseed never consumes a step
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg <= LFSR_SEED;
    end else if (load) begin
      state_reg <= LFSR_SEED;
    end else if (advance) begin
      state_reg <= {state_reg[LFSR_W-2:0], state_reg[LFSR_W-1] ^ state_reg[LFSR_W-2]};
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/prbs_checker.sv
// PRBS byte-stream checker: hunts for a repeated 32-bit preamble, then compares bytes against the LFSR.
// Optional per-bit error counting is enabled with macro PRBS_CHECKER_BIT_ERR_EN.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int ERR_W = 16,
  parameter int CNT_W = 24
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  input  logic [7:0]       n,
  input  logic [31:0]      pattern,
  output logic             pat_lock,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] bit_err_count,
  output logic [CNT_W-1:0] byte_count
);

  state_e            state_reg, state_next;
  logic [1:0]        byte_idx_reg, byte_idx_next;
  logic [7:0]        rep_reg, rep_next;
  logic              err_flag_reg;
  logic [ERR_W-1:0]  err_count_reg;
  logic [CNT_W-1:0]  byte_count_reg;

  logic              lfsr_load;
  logic              lfsr_advance;
  logic              check_en;
  logic              mismatch;
  logic [LFSR_W-1:0] lfsr_state;
  logic [7:0]        exp_byte;
  logic [7:0]        pat_byte;
  logic              unused_lfsr_hi;

  prbs_lfsr u_lfsr (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .load    (lfsr_load),
    .advance (lfsr_advance),
    .state   (lfsr_state)
  );

  assign exp_byte       = lfsr_state[7:0];
  assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:8];
  assign pat_byte       = pattern[{byte_idx_reg, 3'b000} +: 8];
  assign mismatch       = check_en && (in != exp_byte);

  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    rep_next      = rep_reg;
    lfsr_load     = 1'b0;
    lfsr_advance  = 1'b0;
    check_en      = 1'b0;
    if (clr) begin
      state_next    = HUNT;
      byte_idx_next = 2'd0;
      rep_next      = 8'd0;
      lfsr_load     = 1'b1;
    end else if (in_valid) begin
      case (state_reg)
        HUNT: begin
          if (in == pattern[7:0]) begin
            state_next    = PREAMBLE;
            byte_idx_next = 2'd1;
            rep_next      = 8'd0;
          end
        end
        PREAMBLE: begin
          if (in == pat_byte) begin
            if (byte_idx_reg != 2'(PREAMBLE_BYTES - 1)) begin
              byte_idx_next = byte_idx_reg + 2'd1;
            end else if (rep_reg != n) begin
              byte_idx_next = 2'd0;
              rep_next      = rep_reg + 8'd1;
            end else begin
              state_next    = CHECK;
              byte_idx_next = 2'd0;
              rep_next      = 8'd0;
              lfsr_load     = 1'b1;
            end
          end else if (in == pattern[7:0]) begin
            // a broken preamble may itself be the start of a fresh one
            byte_idx_next = 2'd1;
            rep_next      = 8'd0;
          end else begin
            state_next    = HUNT;
            byte_idx_next = 2'd0;
            rep_next      = 8'd0;
          end
        end
        CHECK: begin
          check_en     = 1'b1;
          lfsr_advance = 1'b1;
        end
        default: begin
          state_next    = HUNT;
          byte_idx_next = 2'd0;
          rep_next      = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg      <= HUNT;
      byte_idx_reg   <= 2'd0;
      rep_reg        <= 8'd0;
      err_flag_reg   <= 1'b0;
      err_count_reg  <= '0;
      byte_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      byte_idx_reg <= byte_idx_next;
      rep_reg      <= rep_next;
      if (clr) begin
        err_flag_reg   <= 1'b0;
        err_count_reg  <= '0;
        byte_count_reg <= '0;
      end else begin
        err_flag_reg <= mismatch;
        if (mismatch && (err_count_reg != '1)) begin
          err_count_reg <= err_count_reg + 1'b1;
        end
        if (check_en && (byte_count_reg != '1)) begin
          byte_count_reg <= byte_count_reg + 1'b1;
        end
      end
    end
  end

`ifdef PRBS_CHECKER_BIT_ERR_EN
  logic [ERR_W-1:0] bit_err_count_reg;
  logic [ERR_W:0]   bit_sum;

  // one extra bit catches the overflow so the counter can clamp at all-ones
  assign bit_sum = {1'b0, bit_err_count_reg} + (ERR_W+1)'(popcount8(in ^ exp_byte));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bit_err_count_reg <= '0;
    end else if (clr) begin
      bit_err_count_reg <= '0;
    end else if (check_en) begin
      bit_err_count_reg <= bit_sum[ERR_W] ? '1 : bit_sum[ERR_W-1:0];
    end
  end

  assign bit_err_count = bit_err_count_reg;
`else
  assign bit_err_count = '0;
`endif

  assign pat_lock   = (state_reg == CHECK);
  assign err_flag   = err_flag_reg;
  assign err_count  = err_count_reg;
  assign byte_count = byte_count_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed scoreboard bench for prbs_checker: preamble hunting, PRBS checking, clr and async reset.
module tb_prbs_checker;

  localparam int ERR_W = 16;
  localparam int CNT_W = 24;

  logic             CLK = 1'b0;
  logic             RSTn;
  logic             clr;
  logic             in_valid;
  logic [7:0]       in;
  logic [7:0]       n;
  logic [31:0]      pattern;
  logic             pat_lock;
  logic             err_flag;
  logic [ERR_W-1:0] err_count;
  logic [ERR_W-1:0] bit_err_count;
  logic [CNT_W-1:0] byte_count;

  prbs_checker #(.ERR_W(ERR_W), .CNT_W(CNT_W)) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .clr           (clr),
    .in_valid      (in_valid),
    .in            (in),
    .n             (n),
    .pattern       (pattern),
    .pat_lock      (pat_lock),
    .err_flag      (err_flag),
    .err_count     (err_count),
    .bit_err_count (bit_err_count),
    .byte_count    (byte_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] byte_in;
    logic       err;
    int         bytes;
    int         errs;
    int         bits;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [15:0] m_lfsr;
  int         m_bytes, m_errs, m_bits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_lfsr  = 16'h0011;
    m_bytes = 0;
    m_errs  = 0;
    m_bits  = 0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, ".byte_count"}, 32'(byte_count), 32'(m_bytes));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_errs));
    check({tag, ".bit_err_count"}, 32'(bit_err_count), 32'(m_bits));
  endtask

  // chk=1 means the byte is expected to be compared against the PRBS sequence
  task automatic send(input logic [7:0] b, input bit chk);
    exp_t e;
    exp_t got;
    logic [7:0] want;
    e.byte_in = b;
    e.err = 1'b0;
    if (chk) begin
      want = m_lfsr[7:0];
      e.err = (b != want);
      m_bytes++;
      if (e.err) m_errs++;
`ifdef PRBS_CHECKER_BIT_ERR_EN
      m_bits += $countones(b ^ want);
`endif
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14]};
    end
    e.bytes = m_bytes;
    e.errs  = m_errs;
    e.bits  = m_bits;
    sb.push_back(e);
    in_valid = 1'b1;
    in       = b;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    got = sb.pop_front();
    $display("byte %02h chk=%0d lock=%0d err_flag=%0d bytes=%0d errs=%0d bits=%0d",
             got.byte_in, chk, pat_lock, err_flag, byte_count, err_count, bit_err_count);
    check("err_flag", 32'(err_flag), 32'(got.err));
    check("byte_count", 32'(byte_count), 32'(got.bytes));
    check("err_count", 32'(err_count), 32'(got.errs));
    check("bit_err_count", 32'(bit_err_count), 32'(got.bits));
  endtask

  task automatic send_preamble();
    send(8'hEF, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hDE, 1'b0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge CLK);
      #1;
      $display("idle cycle %0d lock=%0d err_flag=%0d", i, pat_lock, err_flag);
      check("idle.err_flag", 32'(err_flag), 32'd0);
      check("idle.byte_count", 32'(byte_count), 32'(m_bytes));
    end
  endtask

  // clr together with a valid byte: the byte must be discarded
  task automatic do_clr();
    clr      = 1'b1;
    in_valid = 1'b1;
    in       = m_lfsr[7:0];
    @(posedge CLK);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    model_reset();
    $display("clr lock=%0d bytes=%0d errs=%0d", pat_lock, byte_count, err_count);
    check("clr.pat_lock", 32'(pat_lock), 32'd0);
    check("clr.err_flag", 32'(err_flag), 32'd0);
    check_counts("clr");
  endtask

  task automatic rst_pulse(input string tag);
    #2 RSTn = 1'b0;
    #1;
    model_reset();
    $display("reset %s lock=%0d err_flag=%0d bytes=%0d", tag, pat_lock, err_flag, byte_count);
    check({tag, ".pat_lock"}, 32'(pat_lock), 32'd0);
    check({tag, ".err_flag"}, 32'(err_flag), 32'd0);
    check_counts(tag);
    #1 RSTn = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RSTn     = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in       = 8'h00;
    n        = 8'd0;
    pattern  = 32'hDEADBEEF;
    model_reset();
    #1;
    check("reset.pat_lock", 32'(pat_lock), 32'd0);
    check("reset.err_flag", 32'(err_flag), 32'd0);
    check_counts("reset");
    @(posedge CLK);
    @(posedge CLK);
    #1 RSTn = 1'b1;

    // single preamble, then five clean PRBS bytes
    send(8'hEF, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hAD, 1'b0);
    check("t1.lock_before_de", 32'(pat_lock), 32'd0);
    send(8'hDE, 1'b0);
    check("t1.lock_after_de", 32'(pat_lock), 32'd1);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h44, 1'b1);
    send(8'h88, 1'b1);
    send(8'h10, 1'b1);
    check("t1.byte_count", 32'(byte_count), 32'd5);
    check("t1.err_count", 32'(err_count), 32'd0);
    do_clr();

    // two preamble repetitions required
    n = 8'd1;
    send_preamble();
    check("t2.lock_after_first", 32'(pat_lock), 32'd0);
    send_preamble();
    check("t2.lock_after_second", 32'(pat_lock), 32'd1);
    send(8'h11, 1'b1);
    check("t2.byte_count", 32'(byte_count), 32'd1);
    do_clr();

    // one single-bit error
    n = 8'd0;
    send_preamble();
    send(8'h11, 1'b1);
    send(8'h23, 1'b1);
    send(8'h44, 1'b1);
    check("t3.err_count", 32'(err_count), 32'd1);
`ifdef PRBS_CHECKER_BIT_ERR_EN
    check("t3.bit_err_count", 32'(bit_err_count), 32'd1);
`else
    check("t3.bit_err_count", 32'(bit_err_count), 32'd0);
`endif
    check("t3.still_locked", 32'(pat_lock), 32'd1);
    do_clr();

    // preamble restart on a repeated first byte, then gaps in in_valid
    send(8'hEF, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hEF, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hAD, 1'b0);
    check("t4.lock_before_de", 32'(pat_lock), 32'd0);
    send(8'hDE, 1'b0);
    check("t4.lock_after_de", 32'(pat_lock), 32'd1);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    idle(3);
    send(8'h44, 1'b1);
    check("t5.err_count", 32'(err_count), 32'd0);
    do_clr();

    // reset mid-preamble: partial preamble must not count
    send(8'hEF, 1'b0);
    send(8'hBE, 1'b0);
    rst_pulse("rst_pre");
    send(8'hAD, 1'b0);
    send(8'hDE, 1'b0);
    check("t6.no_lock_partial", 32'(pat_lock), 32'd0);
    send_preamble();
    check("t6.lock_full", 32'(pat_lock), 32'd1);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);

    // reset mid-check
    rst_pulse("rst_chk");
    send(8'h11, 1'b0);
    check("t6.no_lock_after_rst", 32'(pat_lock), 32'd0);
    send_preamble();
    check("t6.relock", 32'(pat_lock), 32'd1);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
